act_window_regfile_kxk: RTL
===========================

# act_window_regfile_kxk

Parametrised K×K activation window register file for the convolution datapath; successor to the fixed 3×3 sliding-patch register. It accepts one K-row activation column per handshake and shifts it into a K×K window. It optionally inserts zero columns at the left and right edges for "same" padding, and presents each complete window to the PE array through a valid/ready handshake with backpressure. It sits between the activation line buffers and the MAC array, and sequences one row pass per `start`.

## Interface
- `DATA_WIDTH`, 16, activation element width.
- `K`, 3, window size; odd, 3..7.
- `COL_W`, 8, width of column count.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin row pass; latches `cfg_cols` and `cfg_pad`.
- `cfg_cols` in COL_W: real columns in the pass.
- `cfg_pad` in 1: 1 = insert P=(K-1)/2 zero columns on each side.
- `col_valid` in 1: `col_data` valid.
- `col_ready` out 1: column accepted when `col_valid && col_ready`.
- `col_data` in DATA_WIDTH*K: row r at `[DATA_WIDTH*K-1-DATA_WIDTH*r -: DATA_WIDTH]`; row 0 is top.
- `out_valid` out 1: `out_window` holds a complete window.
- `out_ready` in 1: consumer accepts the window.
- `out_window` out DATA_WIDTH*K*K: element (r,c) at `[DATA_WIDTH*K*K-1-DATA_WIDTH*(r*K+c) -: DATA_WIDTH]`; c=0 is the oldest (leftmost) column.
- `out_last` out 1: qualifies the final window of the pass.
- `busy` out 1: high from accepted `start` until the last window is consumed.

## Operation
- FSM states: IDLE, PAD_L, LOAD, PAD_R, DRAIN.
- IDLE: on `start`, latch config and clear the fill count and window count.
  - Go to PAD_L if pad, else LOAD.
  - `start` is ignored when `cfg_cols==0` or `cfg_cols + 2P_eff < K`, where P_eff = P if pad else 0.
- `start` is ignored outside IDLE.
- Shift enable `adv = (!out_valid || out_ready)`. A shift moves every column left by one: column c ← c+1, and column K-1 ← new column.
- PAD_L: each cycle with `adv`, shift in a zero column. After P shifts, go to LOAD.
- LOAD: `col_ready = adv`. Each accepted column shifts in `col_data`. After `cfg_cols` accepted columns, go to PAD_R if pad, else DRAIN.
- PAD_R: like PAD_L, P zero columns, then go to DRAIN.
- DRAIN: wait until the final window is accepted, then go to IDLE.
- Fill counter saturates at K. Each shift that leaves fill==K sets `out_valid` next cycle.
- A window accepted without a simultaneous shift clears `out_valid`.
- Windows per pass: W = cfg_cols + 2P_eff − K + 1. The window counter counts emitted windows; `out_last` is asserted with window W.
- Window contents persist after a pass. They are zeroed only by reset, never by `start`.
- `col_ready` is 0 outside LOAD. `col_data` is not sampled outside LOAD.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_window`=0, `busy`=0, `col_ready`=0, state IDLE, all counters 0.
- `rst` asserted in any state returns to IDLE at the next edge and discards a partially built window.
- `start` at cycle t → `busy`=1 at t+1. The first PAD_L shift or the first `col_ready` is at t+1.
- Column accepted at t → the updated window is registered at t+1, and `out_valid` rises at t+1 if fill reaches K.
- Throughput is one window per cycle when `out_ready` is held high and columns stream every cycle.
- `out_valid` && !`out_ready`: `out_window` and `out_last` are held stable, with no shift and `col_ready`=0.
- `col_ready` depends combinationally on `out_valid`/`out_ready`; there is no path from `col_valid` to `col_ready`.
- Last window accepted at t → `busy`=0 and `out_valid`=0 at t+1. A new `start` is accepted at t+1.

## Test plan
- **No-pad pass.** K=3, `cfg_cols`=4, pad=0, columns {1,1,1},{2,2,2},{3,3,3},{4,4,4} streamed, `out_ready`=1 → exactly 2 windows:
  - row 0 = (1,2,3), then (2,3,4).
  - `out_last` on the 2nd window.
  - `busy` drops the cycle after.
- **Padded pass.** K=3, `cfg_cols`=4, pad=1, same columns → 4 windows with row 0 = (0,1,2), (1,2,3), (2,3,4), (3,4,0); `out_last` on the 4th.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles mid-pass → `col_ready`=0 and `out_window` constant. Release → streaming resumes with no lost or duplicated window.
- **Illegal or mid-pass start.**
  - `cfg_cols`=1, pad=0, K=3 → `busy` stays 0.
  - `start` mid-pass → ignored; the window count is unchanged.
- **Reset mid-pass.** `rst` during LOAD after 2 columns → next cycle all outputs at reset values and state IDLE. A fresh pass then runs correctly.
- **K=5, pad=1, `cfg_cols`=5** → 5 windows. The first window has columns (0,0,c1,c2,c3) on every row, and the element placement matches the (r,c) index map.

Source files
------------

// File: rtl/act_window_regfile_kxk.sv
// K x K activation window register file: shifts one K-row column per handshake into
// the window, optionally framing each row pass with zero columns for "same" padding.
module act_window_regfile_kxk #(
  parameter int DATA_WIDTH = 16,
  parameter int K          = 3,
  parameter int COL_W      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [COL_W-1:0]          cfg_cols,
  input  logic                      cfg_pad,
  input  logic                      col_valid,
  output logic                      col_ready,
  input  logic [DATA_WIDTH*K-1:0]   col_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH*K*K-1:0] out_window,
  output logic                      out_last,
  output logic                      busy
);

  localparam int P    = (K - 1) / 2;
  localparam int FW   = $clog2(K + 1);
  localparam int WC_W = COL_W + 2;

  typedef enum logic [2:0] {IDLE, PAD_L, LOAD, PAD_R, DRAIN} state_t;

  state_t state, state_n;

  logic [COL_W-1:0]      cols_q;
  logic                  pad_q;
  logic [COL_W-1:0]      step_cnt;
  logic [FW-1:0]         fill;
  logic [FW-1:0]         fill_n;
  logic [WC_W-1:0]       win_cnt;
  logic [WC_W-1:0]       win_total;
  logic [WC_W-1:0]       span;
  logic [DATA_WIDTH-1:0] win    [K][K];
  logic [DATA_WIDTH-1:0] in_col [K];

  logic adv, pad_phase, shift, emit, start_ok, pad_done, load_done;

  always_comb begin
    adv       = !out_valid || out_ready;
    pad_phase = (state == PAD_L) || (state == PAD_R);
    col_ready = (state == LOAD) && adv;
    shift     = (pad_phase && adv) || (col_ready && col_valid);
    fill_n    = (fill == FW'(K)) ? fill : fill + FW'(1);
    emit      = shift && (fill_n == FW'(K));
    span      = {2'b00, cfg_cols} + (cfg_pad ? WC_W'(2 * P) : '0);
    start_ok  = (state == IDLE) && start && (cfg_cols != '0) && (span >= WC_W'(K));
    pad_done  = pad_phase && shift && (step_cnt == COL_W'(P - 1));
    load_done = (state == LOAD) && shift && (step_cnt == cols_q - COL_W'(1));
    busy      = (state != IDLE);
  end

  // Incoming column: real data only while loading, zeros for the padding phases.
  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      in_col[r] = (state == LOAD) ? col_data[DATA_WIDTH*K-1-DATA_WIDTH*r -: DATA_WIDTH] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start_ok) state_n = cfg_pad ? PAD_L : LOAD;
      PAD_L:   if (pad_done) state_n = LOAD;
      LOAD:    if (load_done) state_n = pad_q ? PAD_R : DRAIN;
      PAD_R:   if (pad_done) state_n = DRAIN;
      DRAIN:   if (out_valid && out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cols_q    <= '0;
      pad_q     <= 1'b0;
      step_cnt  <= '0;
      fill      <= '0;
      win_cnt   <= '0;
      win_total <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      // A new pass restarts the fill count but keeps the old window contents.
      if (start_ok) begin
        cols_q    <= cfg_cols;
        pad_q     <= cfg_pad;
        win_total <= span - WC_W'(K - 1);
        fill      <= '0;
        win_cnt   <= '0;
        step_cnt  <= '0;
      end else if (pad_done || load_done) begin
        step_cnt <= '0;
      end else if (shift) begin
        step_cnt <= step_cnt + COL_W'(1);
      end

      if (shift) begin
        fill <= fill_n;
        for (int unsigned r = 0; r < K; r++) begin
          for (int unsigned c = 0; c + 1 < K; c++) begin
            win[r][c] <= win[r][c+1];
          end
          win[r][K-1] <= in_col[r];
        end
      end

      if (emit) begin
        out_valid <= 1'b1;
        win_cnt   <= win_cnt + WC_W'(1);
        out_last  <= (win_cnt + WC_W'(1) == win_total);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  always_comb begin
    out_window = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        out_window[DATA_WIDTH*K*K-1-DATA_WIDTH*(r*K+c) -: DATA_WIDTH] = win[r][c];
      end
    end
  end

endmodule
